// File: rtl/hex_display_bank_if.sv
// Bus between the datapath and the display bank: values to show, the raw key,
// the mode controls, and the registered HEX/LEDR pin drives coming back.
interface hex_display_bank_if #(
    parameter int N_DIGITS = 6,
    parameter int LED_W    = 10
);
    logic [4*N_DIGITS-1:0] data;
    logic [LED_W-1:0]      leds_in;
    logic                  capture_n;
    logic [1:0]            mode;
    logic                  blank_lz;
    logic [7*N_DIGITS-1:0] hex_out;
    logic [LED_W-1:0]      ledr;
    logic                  snap_valid;

    modport master (
        output data, leds_in, capture_n, mode, blank_lz,
        input  hex_out, ledr, snap_valid
    );

    modport slave (
        input  data, leds_in, capture_n, mode, blank_lz,
        output hex_out, ledr, snap_valid
    );
endinterface

// File: rtl/hex_display_bank.sv
// Capture-and-hold bank for the seven-segment digits and LED bar: debounced
// snapshot key, live/snap/blink/freeze modes and optional leading-zero blanking.
module hex_display_bank #(
    parameter int N_DIGITS        = 6,
    parameter int LED_W           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 12500000
) (
    input  logic              CLOCK_50,
    input  logic              RESETn,
    hex_display_bank_if.slave bus
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BL_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_LIVE   = 2'b00,
        MODE_SNAP   = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_FREEZE = 2'b11
    } mode_t;

    mode_t                 cur_mode;
    logic [1:0]            sync_reg;
    logic                  key_level_reg;
    logic [DB_W-1:0]       db_cnt_reg;
    logic                  press_reg;
    logic [BL_W-1:0]       blink_cnt_reg;
    logic                  blink_on_reg;
    logic [4*N_DIGITS-1:0] held_data_reg;
    logic [LED_W-1:0]      held_led_reg;
    logic                  snap_valid_reg;
    logic [7*N_DIGITS-1:0] seg_enc;
    logic [7*N_DIGITS-1:0] hex_reg, hex_next;
    logic [LED_W-1:0]      ledr_reg, ledr_next;

    assign cur_mode = mode_t'(bus.mode);

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0:    seg_of = 7'h40;
            4'h1:    seg_of = 7'h79;
            4'h2:    seg_of = 7'h24;
            4'h3:    seg_of = 7'h30;
            4'h4:    seg_of = 7'h19;
            4'h5:    seg_of = 7'h12;
            4'h6:    seg_of = 7'h02;
            4'h7:    seg_of = 7'h78;
            4'h8:    seg_of = 7'h00;
            4'h9:    seg_of = 7'h10;
            4'hA:    seg_of = 7'h08;
            4'hB:    seg_of = 7'h03;
            4'hC:    seg_of = 7'h46;
            4'hD:    seg_of = 7'h21;
            4'hE:    seg_of = 7'h06;
            default: seg_of = 7'h0E;
        endcase
    endfunction

    // Key path: the press pulse is the accepted level falling, registered one cycle.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            sync_reg      <= 2'b11;
            key_level_reg <= 1'b1;
            db_cnt_reg    <= '0;
            press_reg     <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[0], bus.capture_n};
            press_reg <= 1'b0;
            if (sync_reg[1] == key_level_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_cnt_reg    <= '0;
                key_level_reg <= sync_reg[1];
                press_reg     <= key_level_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= 1'b1;
        end else if (blink_cnt_reg == BL_LAST) begin
            blink_cnt_reg <= '0;
            blink_on_reg  <= ~blink_on_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // The mode sampled on this edge decides whether a coincident press loads.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            held_data_reg  <= '0;
            held_led_reg   <= '0;
            snap_valid_reg <= 1'b0;
        end else begin
            case (cur_mode)
                MODE_LIVE: begin
                    held_data_reg  <= bus.data;
                    held_led_reg   <= bus.leds_in;
                    snap_valid_reg <= 1'b0;
                end
                MODE_SNAP, MODE_BLINK: begin
                    if (press_reg) begin
                        held_data_reg  <= bus.data;
                        held_led_reg   <= bus.leds_in;
                        snap_valid_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
        logic [3:0] nib;
        logic       blank;
        assign nib = held_data_reg[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign blank = 1'b0;
        end else begin : g_upper
            // Blank only when this digit and every digit above it is zero.
            assign blank = bus.blank_lz & (held_data_reg[4*N_DIGITS-1:4*gi] == '0);
        end
        assign seg_enc[7*gi +: 7] = blank ? 7'h7F : seg_of(nib);
    end

    always_comb begin
        hex_next  = seg_enc;
        ledr_next = held_led_reg;
        if (cur_mode != MODE_LIVE && !snap_valid_reg) begin
            hex_next  = '1;
            ledr_next = '0;
        end else if (cur_mode == MODE_BLINK && !blink_on_reg) begin
            hex_next = '1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            hex_reg  <= '1;
            ledr_reg <= '0;
        end else begin
            hex_reg  <= hex_next;
            ledr_reg <= ledr_next;
        end
    end

    assign bus.hex_out    = hex_reg;
    assign bus.ledr       = ledr_reg;
    assign bus.snap_valid = snap_valid_reg;
endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench for hex_display_bank: expected pin states are queued with the
// edge they are due on and compared when that edge has produced them.
module tb_hex_display_bank;
    localparam int N  = 6;
    localparam int LW = 10;
    localparam int DB = 4;
    localparam int BL = 8;
    localparam int HW = 7*N;
    localparam logic [HW-1:0] ALL_BLANK = '1;

    logic CLOCK_50 = 1'b0;
    logic RESETn   = 1'b0;

    hex_display_bank_if #(.N_DIGITS(N), .LED_W(LW)) bus ();

    hex_display_bank #(
        .N_DIGITS(N), .LED_W(LW), .DEBOUNCE_CYCLES(DB), .BLINK_CYCLES(BL)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESETn  (RESETn),
        .bus     (bus)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [HW-1:0] hex;
        logic [LW-1:0] led;
        logic          sv;
        int            due;
        string         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   cyc        = 0;
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   blink_base = 0;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [HW-1:0] exp_hex(input logic [4*N-1:0] d, input logic blz);
        logic [HW-1:0] r;
        logic [3:0]    nib;
        bit            lead;
        r    = '0;
        lead = 1'b1;
        for (int i = N-1; i >= 0; i--) begin
            nib = d[4*i +: 4];
            if (blz && lead && nib == 4'h0 && i != 0) r[7*i +: 7] = 7'h7F;
            else begin
                lead = 1'b0;
                r[7*i +: 7] = seg7(nib);
            end
        end
        return r;
    endfunction

    // Phase used by the output register at edge ed (counted from the first edge after reset).
    function automatic bit blink_on_at(input int ed);
        return (((ed - blink_base) / BL) % 2) == 0;
    endfunction

    task automatic step();
        @(posedge CLOCK_50);
        #1;
        cyc++;
    endtask

    task automatic push(input logic [HW-1:0] hex, input logic [LW-1:0] led, input logic sv,
                        input int due, input string tag);
        exp_t x;
        x.hex = hex; x.led = led; x.sv = sv; x.due = due; x.tag = tag;
        exp_q.push_back(x);
    endtask

    task automatic test_reset();
        bus.data = '0; bus.leds_in = '0; bus.capture_n = 1'b1; bus.mode = 2'b00; bus.blank_lz = 1'b0;
        RESETn = 1'b0;
        push(ALL_BLANK, '0, 1'b0, cyc + 3, "reset_state");
        for (int k = 1; k <= 3; k++) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front(); n_checks++;
                if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                             e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
                end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
            end
        end
        RESETn     = 1'b1;
        blink_base = cyc + 1;
    endtask

    task automatic test_live();
        int c;
        c = cyc;
        bus.mode = 2'b00; bus.blank_lz = 1'b0; bus.data = 24'h12AB0F; bus.leds_in = 10'h3A5;
        push(exp_hex(24'h0, 1'b0), '0, 1'b0, c + 1, "live_latency");
        push({7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E}, 10'h3A5, 1'b0, c + 2, "live_first");
        push({7'h79, 7'h24, 7'h08, 7'h03, 7'h40, 7'h0E}, 10'h3A5, 1'b0, c + 3, "live_hold");
        push(exp_hex(24'h345678, 1'b0), 10'h0C3, 1'b0, c + 4, "live_follow");
        for (int k = 1; k <= 4; k++) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front(); n_checks++;
                if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                             e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
                end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
            end
            if (k == 2) begin bus.data = 24'h345678; bus.leds_in = 10'h0C3; end
        end
    endtask

    task automatic test_leading_zero();
        int c;
        c = cyc;
        bus.blank_lz = 1'b1; bus.data = 24'h000305;
        push({7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}, 10'h0C3, 1'b0, c + 2, "lz_305");
        push({7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h40, 7'h12}, 10'h0C3, 1'b0, c + 3, "lz_305_hold");
        push({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 10'h0C3, 1'b0, c + 4, "lz_all_zero");
        for (int k = 1; k <= 4; k++) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front(); n_checks++;
                if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                             e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
                end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
            end
            if (k == 2) bus.data = 24'h000000;
        end
    endtask

    task automatic test_debounce();
        int c;
        logic [HW-1:0] snap;
        c    = cyc;
        snap = {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24};
        bus.mode = 2'b01; bus.blank_lz = 1'b0; bus.data = 24'h000042; bus.leds_in = 10'h155;
        bus.capture_n = 1'b0;
        push(ALL_BLANK, '0, 1'b0, c + 1,  "snap_empty");
        push(ALL_BLANK, '0, 1'b0, c + 10, "snap_glitch_ignored");
        push(ALL_BLANK, '0, 1'b1, c + 11, "snap_valid_at_load");
        push(snap, 10'h155, 1'b1, c + 12, "snap_shown");
        push(snap, 10'h155, 1'b1, c + 22, "snap_single_event");
        for (int k = 1; k <= 22; k++) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front(); n_checks++;
                if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                             e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
                end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
            end
            case (k)
                3:  bus.capture_n = 1'b1;
                4:  bus.capture_n = 1'b0;
                12: begin bus.data = 24'h999999; bus.leds_in = 10'h2AA; end
                14: bus.capture_n = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic test_blink();
        int c;
        logic [HW-1:0] snap;
        c    = cyc;
        snap = exp_hex(24'h000042, 1'b0);
        bus.mode = 2'b10;
        for (int ed = c + 1; ed <= c + 24; ed++)
            push(blink_on_at(ed) ? snap : ALL_BLANK, 10'h155, 1'b1, ed, "blink");
        push(snap, 10'h155, 1'b1, c + 25, "blink_exit");
        push(snap, 10'h155, 1'b1, c + 26, "blink_exit_steady");
        for (int k = 1; k <= 26; k++) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front(); n_checks++;
                if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                             e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
                end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
            end
            if (k == 24) bus.mode = 2'b01;
        end
    endtask

    task automatic test_async_reset();
        bus.mode = 2'b10;
        bus.capture_n = 1'b0;
        step();
        step();
        #2;
        RESETn = 1'b0;
        #1;
        push(ALL_BLANK, '0, 1'b0, cyc, "async_reset");
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front(); n_checks++;
            if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                n_fail++;
                $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                         e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
            end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
        end
        bus.mode = 2'b00;
        bus.capture_n = 1'b1;
        step();
        step();
        RESETn     = 1'b1;
        blink_base = cyc + 1;
    endtask

    task automatic test_freeze_live();
        int c;
        logic [HW-1:0] snap;
        c    = cyc;
        snap = exp_hex(24'h00ABCD, 1'b1);
        bus.mode = 2'b01; bus.blank_lz = 1'b1; bus.data = 24'h00ABCD; bus.leds_in = 10'h2F0;
        bus.capture_n = 1'b0;
        push(ALL_BLANK, '0, 1'b0, c + 1, "fz_empty");
        push(ALL_BLANK, '0, 1'b1, c + 7, "fz_load");
        push(snap, 10'h2F0, 1'b1, c + 8,  "fz_snap");
        push(snap, 10'h2F0, 1'b1, c + 17, "freeze_enter");
        push(snap, 10'h2F0, 1'b1, c + 24, "freeze_press_ignored");
        push(snap, 10'h2F0, 1'b1, c + 28, "freeze_hold");
        push(snap, 10'h2F0, 1'b0, c + 31, "live_clears_valid");
        push(exp_hex(24'h111111, 1'b1), 10'h3FF, 1'b0, c + 32, "live_reload");
        push(ALL_BLANK, '0, 1'b0, c + 33, "snap_without_press");
        for (int k = 1; k <= 33; k++) begin
            step();
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front(); n_checks++;
                if ({bus.hex_out, bus.ledr, bus.snap_valid} !== {e.hex, e.led, e.sv}) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d hex=%h ledr=%h sv=%b expected hex=%h ledr=%h sv=%b",
                             e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid, e.hex, e.led, e.sv);
                end else $display("ok   %s cyc=%0d hex=%h ledr=%h sv=%b", e.tag, cyc, bus.hex_out, bus.ledr, bus.snap_valid);
            end
            case (k)
                8:  bus.capture_n = 1'b1;
                16: begin
                    bus.mode = 2'b11; bus.data = 24'h111111; bus.leds_in = 10'h3FF;
                    bus.capture_n = 1'b0;
                end
                26: bus.capture_n = 1'b1;
                30: bus.mode = 2'b00;
                32: bus.mode = 2'b01;
                default: ;
            endcase
        end
    endtask

    initial begin
        test_reset();
        test_live();
        test_leading_zero();
        test_debounce();
        test_blink();
        test_async_reset();
        test_freeze_live();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d results still pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hex_display_bank.md
# hex_display_bank

Parametrised, debounced capture-and-hold register bank for the seven-segment and LED outputs. It replaces per-digit display latches with one block that drives N_DIGITS active-low hex displays and an LED bar. It has four modes: live, snapshot on key press, snapshot with blink, and freeze. The raw push-button input is synchronised and debounced internally, and leading-zero blanking is optional. It sits between the datapath (register-file and ALU results) and the board's HEX/LEDR pins.

## Interface
- N_DIGITS, 6: number of hex digits driven.
- LED_W, 10: LED bar width.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a key level change (10 ms at 50 MHz); minimum 1.
- BLINK_CYCLES, 12500000: blink half-period in cycles; minimum 1.
- CLOCK_50  in  1  sole clock; all state changes on its rising edge.
- RESETn  in  1  reset, asynchronous, active-low.
- data  in  4*N_DIGITS  nibble i = data[4i+3:4i] is shown on digit i.
- leds_in  in  LED_W  LED pattern to hold/show.
- capture_n  in  1  raw, asynchronous, active-low push-button.
- mode  in  2  00 LIVE, 01 SNAP, 10 SNAP_BLINK, 11 FREEZE.
- blank_lz  in  1  1 = blank leading zero digits.
- hex_out  out  7*N_DIGITS  digit i = hex_out[7i+6:7i], active-low gfedcba.
- ledr  out  LED_W  registered LED output.
- snap_valid  out  1  1 = held value came from a capture since reset or since the last LIVE cycle.

## Operation
- Key path:
  - Two-flop synchroniser on capture_n, then a debouncer.
  - The debouncer holds an accepted level, which resets to 1 (released).
  - A counter increments while the synchronised level differs from the accepted level.
  - Any sample equal to the accepted level clears the counter to 0.
  - When the counter reaches DEBOUNCE_CYCLES, the accepted level flips and the counter clears.
  - A flip 1→0 produces a one-cycle press pulse. A flip 0→1 produces no event.
- Hold registers held_data and held_led, load rule per cycle:
  - LIVE: load data and leds_in every cycle; snap_valid <= 0.
  - SNAP, SNAP_BLINK: load only on a press pulse; snap_valid <= 1 on that pulse.
  - FREEZE: never load. Press pulses are ignored and snap_valid is unchanged.
  - In LIVE, a press pulse is ignored.
- The mode value used is the one sampled on the same edge. A mode change and a press on the same edge are resolved by the new mode's rule.
- Segment encoding, active-low:
  - Digits 0–9: 40 79 24 30 19 12 02 78 00 10.
  - Digits A–F: 08 03 46 21 06 0E.
  - Blank = 7F.
- Leading-zero blanking, when blank_lz=1:
  - Scanning from digit N_DIGITS-1 downward, zero nibbles are blanked until the first nonzero nibble.
  - Digit 0 is never blanked by this rule.
- Output stage, registered, evaluated on held values:
  - mode≠LIVE and snap_valid=0: all digits 7F, ledr 0.
  - mode=SNAP_BLINK and blink phase off: all digits 7F, ledr = held_led (LEDs do not blink).
  - Otherwise: encoded digits with blanking applied; ledr = held_led.
- Blink counter:
  - Free-running in all modes, counting 0..BLINK_CYCLES-1.
  - Toggles the blink phase on wrap.
  - The phase resets to on; the counter resets to 0.

## Timing
- Reset (asynchronous, immediate):
  - hex_out all 7F, ledr 0, snap_valid 0.
  - held registers 0, all counters 0, accepted key level 1, blink phase on.
  - Reset asserted mid-debounce or mid-blink discards all progress.
- LIVE latency: data/leds_in → hold register 1 cycle, → hex_out/ledr 1 more cycle, 2 cycles total.
- Press latency:
  - capture_n is sampled low continuously from edge t.
  - The press pulse is high during the cycle after edge t+DEBOUNCE_CYCLES+1.
  - The hold registers load the data present in that cycle, at edge t+DEBOUNCE_CYCLES+2.
  - hex_out and snap_valid show the result one edge later (snap_valid at the load edge).
- Glitches shorter than DEBOUNCE_CYCLES samples produce no event.
- A held key produces exactly one event.
- A mode change is reflected on hex_out 1 cycle after it is sampled.
- The blink phase toggles every BLINK_CYCLES cycles.

## Test plan
- Use DEBOUNCE_CYCLES=4, BLINK_CYCLES=8, N_DIGITS=6.
- Reset: assert RESETn=0 asynchronously during an active blink snapshot → hex_out all 7F, ledr 0, snap_valid 0 before the next clock edge.
- LIVE: mode=00, blank_lz=0, data=24'h12AB0F, leds_in=10'h3A5 → after 2 edges, digits 5..0 = 79,24,08,03,40,0E and ledr=3A5. Change data → output follows 2 edges later.
- Debounce: mode=01, data=24'h000042, capture_n low 3 cycles, high 1, low 10 cycles → exactly one load, 6 edges after the second low start. snap_valid=1, then digit1=19, digit0=24.
- Leading zeros: mode=00, blank_lz=1, data=24'h000305 → digits 5..3 = 7F, digit2=30, digit1=40, digit0=12. With data=0 → only digit0=40, others 7F.
- Blink:
  - After a valid snap, set mode=10 → hex_out alternates between the held digits and all 7F every 8 cycles.
  - ledr stays constant throughout.
  - Returning to mode=01 restores the steady display 1 cycle later.
- FREEZE/LIVE interaction:
  - Set mode=11, change data, press key → hex_out, ledr, snap_valid unchanged.
  - Set mode=00 → snap_valid=0 on the next edge.
  - Then set mode=01 with no press → all digits 7F, ledr 0.
